fibo_datapath: RTL and testbench

//  - Execution stage driven by FIBO_FSM: a 4-entry register file, a 3-bit-opcode ALU and a

---
 rtl/fibo_datapath.sv | 164 ++++++++++++++++
 tb/tb_fibo_datapath.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibo_datapath.sv
// -----------------------------------------------------------------------------
// fibo_datapath
//   Execution stage slaved to the Fibonacci sequencing FSM. It holds a 4-entry
//   register file, a 3-bit-opcode ALU and a load mux that selects between n_in
//   and the ALU result. It reports a registered zero flag back to the FSM. On
//   each rising edge of done it captures one register-file entry as the result.
//   This block makes no sequencing decisions of its own.
//
// Parameters
//   WIDTH        data width of register file, ALU, n_in and result
//   RESULT_ADDR  register-file entry copied to result on the done rising edge
//
// Ports
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   n_in          in   WIDTH  term index N, written to RF when load_data=1
//   alu_opcode    in   3      ALU operation
//   rd_addr1      in   2      RF read port A address -> ALU operand A
//   rd_addr2      in   2      RF read port B address -> ALU operand B
//   wrt_addr      in   2      RF write address
//   wrt_en        in   1      RF write enable
//   load_data     in   1      1: write data = n_in, 0: write data = ALU result
//   done          in   1      FSM completion indicator
//   zero_flag     out  1      registered: last written value was zero
//   result        out  WIDTH  captured Fibonacci term
//   result_valid  out  1      one-cycle pulse when result is updated
//   overflow      out  1      sticky ADD carry-out (FIBO_OVF_EN builds only)
//
// Build option
//   FIBO_OVF_EN   when defined, generates the sticky ADD carry-out flag.
//                 When undefined, overflow is tied to 0 and no carry logic
//                 exists.
// -----------------------------------------------------------------------------
module fibo_datapath #(
  parameter int         WIDTH       = 16,
  parameter logic [1:0] RESULT_ADDR = 2'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] n_in,
  input  logic [2:0]       alu_opcode,
  input  logic [1:0]       rd_addr1,
  input  logic [1:0]       rd_addr2,
  input  logic [1:0]       wrt_addr,
  input  logic             wrt_en,
  input  logic             load_data,
  input  logic             done,
  output logic             zero_flag,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             overflow
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_PASA = 3'b100;
  localparam logic [2:0] OP_PASB = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_ONE  = 3'b111;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_rf [4];
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_alu_y;
  logic [WIDTH-1:0] w_wd;
  logic             w_done_rise;
  logic             r_done_q;
  logic             r_zero_flag;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;

  // Reads are combinational. A write in the same cycle is not bypassed, so the
  // operands always reflect the value stored before this clock edge.
  assign w_op_a = r_rf[rd_addr1];
  assign w_op_b = r_rf[rd_addr2];

  // ALU: all results wrap modulo 2^WIDTH (DEC of 0 gives all-ones).
  always_comb begin
    w_alu_y = ZERO_W;
    case (alu_opcode)
      OP_ADD:  w_alu_y = w_op_a + w_op_b;
      OP_SUB:  w_alu_y = w_op_a - w_op_b;
      OP_DEC:  w_alu_y = w_op_a - ONE_W;
      OP_INC:  w_alu_y = w_op_a + ONE_W;
      OP_PASA: w_alu_y = w_op_a;
      OP_PASB: w_alu_y = w_op_b;
      OP_CLR:  w_alu_y = ZERO_W;
      OP_ONE:  w_alu_y = ONE_W;
      default: w_alu_y = ZERO_W;
    endcase
  end

  assign w_wd        = load_data ? n_in : w_alu_y;
  assign w_done_rise = done & ~r_done_q;

  // Register file: single write port, written when wrt_en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_rf[i] <= ZERO_W;
      end
    end else if (wrt_en) begin
      r_rf[wrt_addr] <= w_wd;
    end
  end

  // Zero flag tracks the most recently written value and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_flag <= 1'b0;
    end else if (wrt_en) begin
      r_zero_flag <= (w_wd == ZERO_W);
    end
  end

  // Done capture. The result samples the pre-edge RF contents, so a write to
  // RESULT_ADDR on the same edge does not reach result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q       <= 1'b0;
      r_result       <= ZERO_W;
      r_result_valid <= 1'b0;
    end else begin
      r_done_q       <= done;
      r_result_valid <= w_done_rise;
      if (w_done_rise) begin
        r_result <= r_rf[RESULT_ADDR];
      end
    end
  end

`ifdef FIBO_OVF_EN
  logic [WIDTH:0] w_add_sum;
  logic           r_overflow;

  assign w_add_sum = {1'b0, w_op_a} + {1'b0, w_op_b};

  // Sticky carry-out of an ADD write. A load write starts a new computation
  // and clears the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (wrt_en && load_data) begin
      r_overflow <= 1'b0;
    end else if (wrt_en && (alu_opcode == OP_ADD) && w_add_sum[WIDTH]) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

  assign zero_flag    = r_zero_flag;
  assign result       = r_result;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_fibo_datapath.sv
// -----------------------------------------------------------------------------
// tb_fibo_datapath
//   Self-checking bench for fibo_datapath. A cycle-level reference model
//   (array register file plus plain arithmetic) predicts every output. Each
//   scenario task drives its stimulus and compares the outputs inline.
// -----------------------------------------------------------------------------
module tb_fibo_datapath;

  localparam int         W     = 16;
  localparam logic [1:0] RADDR = 2'd1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_DEC  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_PASA = 3'd4;
  localparam logic [2:0] OP_PASB = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_ONE  = 3'd7;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] n_in;
  logic [2:0]   alu_opcode;
  logic [1:0]   rd_addr1;
  logic [1:0]   rd_addr2;
  logic [1:0]   wrt_addr;
  logic         wrt_en;
  logic         load_data;
  logic         done;
  logic         zero_flag;
  logic [W-1:0] result;
  logic         result_valid;
  logic         overflow;

  // reference model state
  logic [W-1:0] m_rf [4];
  logic         m_zero;
  logic [W-1:0] m_result;
  logic         m_valid;
  logic         m_prev_done;
  logic         m_ovf;

  int n_cmp;
  int n_err;

  fibo_datapath #(.WIDTH(W), .RESULT_ADDR(RADDR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .n_in         (n_in),
    .alu_opcode   (alu_opcode),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .wrt_addr     (wrt_addr),
    .wrt_en       (wrt_en),
    .load_data    (load_data),
    .done         (done),
    .zero_flag    (zero_flag),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_zero      = 1'b0;
    m_result    = '0;
    m_valid     = 1'b0;
    m_prev_done = 1'b0;
    m_ovf       = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] wa, input logic we, input logic ld, input logic [W-1:0] n);
    alu_opcode = op; rd_addr1 = ra; rd_addr2 = rb;
    wrt_addr = wa; wrt_en = we; load_data = ld; n_in = n;
  endtask

  // One clock: predict from the pre-edge state, advance, then settle the model.
  task automatic cyc();
    int unsigned  a, b, y, wd;
    bit           rise;
    bit           carry;
    a = m_rf[rd_addr1];
    b = m_rf[rd_addr2];
    case (alu_opcode)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_DEC:  y = a - 1;
      OP_INC:  y = a + 1;
      OP_PASA: y = a;
      OP_PASB: y = b;
      OP_CLR:  y = 0;
      default: y = 1;
    endcase
    y     = y % (1 << W);
    carry = (alu_opcode == OP_ADD) && ((a + b) >= (1 << W));
    wd    = load_data ? n_in : y;
    rise  = done && !m_prev_done;
    @(posedge clk);
    #1;
    m_valid = rise;
    if (rise) m_result = m_rf[RADDR];
    if (wrt_en) begin
      m_rf[wrt_addr] = wd[W-1:0];
      m_zero = (wd == 0);
`ifdef FIBO_OVF_EN
      if (load_data) m_ovf = 1'b0;
      else if (carry) m_ovf = 1'b1;
`endif
    end
    m_prev_done = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; done = 1'b0;
    drive(OP_PASA, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, '0);
    #12;
    n_cmp++;
    if ({zero_flag, result, result_valid, overflow} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs: got zf=%0b res=%h rv=%0b ovf=%0b, want all 0", zero_flag, result, result_valid, overflow);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    // PASS A of each entry written back onto itself must report zero
    for (int k = 0; k < 4; k++) begin
      drive(OP_PASA, 2'(k), 2'd0, 2'(k), 1'b1, 1'b0, '0);
      cyc();
      n_cmp++;
      if (zero_flag !== 1'b1) begin
        n_err++;
        $display("FAIL reset_rf%0d_zero: got %0b want 1", k, zero_flag);
      end
    end
  endtask

  task automatic test_load();
    drive(OP_CLR, 2'd0, 2'd0, 2'd3, 1'b1, 1'b1, 16'd5);
    cyc();
    n_cmp++;
    if (zero_flag !== 1'b0) begin
      n_err++; $display("FAIL load5_zf: got %0b want 0", zero_flag);
    end
    // copy rf[3] into the result entry and capture it
    drive(OP_PASA, 2'd3, 2'd0, RADDR, 1'b1, 1'b0, '0);
    cyc();
    wrt_en = 1'b0; done = 1'b1; cyc();
    n_cmp++;
    if (result !== 16'd5 || result_valid !== 1'b1) begin
      n_err++; $display("FAIL load5_value: got res=%0d rv=%0b want 5/1", result, result_valid);
    end
    done = 1'b0;
    drive(OP_CLR, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 16'd0);
    cyc();
    n_cmp++;
    if (zero_flag !== 1'b1) begin
      n_err++; $display("FAIL load0_zf: got %0b want 1", zero_flag);
    end
  endtask

  task automatic test_fib_sequence();
    int pulses;
    drive(OP_CLR, 2'd0, 2'd0, 2'd3, 1'b1, 1'b1, 16'd7); cyc();
    drive(OP_ONE, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, '0);    cyc();
    drive(OP_CLR, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0, '0);    cyc();
    for (int it = 1; it <= 7; it++) begin
      drive(OP_ADD,  2'd0, 2'd1, 2'd2, 1'b1, 1'b0, '0); cyc();
      drive(OP_PASB, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, '0); cyc();
      drive(OP_PASA, 2'd2, 2'd0, 2'd1, 1'b1, 1'b0, '0); cyc();
      drive(OP_DEC,  2'd3, 2'd0, 2'd3, 1'b1, 1'b0, '0); cyc();
      n_cmp++;
      if (zero_flag !== (it == 7)) begin
        n_err++; $display("FAIL fib_dec%0d_zf: got %0b want %0b", it, zero_flag, (it == 7));
      end
    end
    wrt_en = 1'b0;
    done = 1'b1;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      if (result_valid) pulses++;
      n_cmp++;
      if (result !== 16'd13) begin
        n_err++; $display("FAIL fib_result_c%0d: got %0d want 13", c, result);
      end
    end
    done = 1'b0; cyc();
    if (result_valid) pulses++;
    n_cmp++;
    if (pulses != 1) begin
      n_err++; $display("FAIL fib_single_pulse: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_read_during_write();
    drive(OP_CLR, 2'd0, 2'd0, 2'd1, 1'b1, 1'b1, 16'd8); cyc();
    // INC reads the old rf[1] on the cycle of the write: 8 -> 9, then 9 -> 10
    drive(OP_INC, 2'd1, 2'd0, 2'd1, 1'b1, 1'b0, '0); cyc();
    cyc();
    wrt_en = 1'b0; done = 1'b1; cyc();
    n_cmp++;
    if (result !== 16'd10) begin
      n_err++; $display("FAIL rdw_inc_chain: got %0d want 10", result);
    end
    done = 1'b0; cyc();
    // write to the result entry on the same edge as the done rise
    drive(OP_CLR, 2'd0, 2'd0, RADDR, 1'b1, 1'b1, 16'd77);
    done = 1'b1; cyc();
    n_cmp++;
    if (result !== 16'd10 || result_valid !== 1'b1) begin
      n_err++; $display("FAIL rdw_done_collision: got res=%0d rv=%0b want 10/1", result, result_valid);
    end
    wrt_en = 1'b0; done = 1'b0; cyc();
    done = 1'b1; cyc();
    n_cmp++;
    if (result !== 16'd77) begin
      n_err++; $display("FAIL rdw_recapture: got %0d want 77", result);
    end
    done = 1'b0; cyc();
  endtask

  task automatic test_wrap_and_overflow();
    drive(OP_CLR, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0, '0); cyc();
    drive(OP_DEC, 2'd1, 2'd0, 2'd1, 1'b1, 1'b0, '0); cyc();
    n_cmp++;
    if (zero_flag !== 1'b0) begin
      n_err++; $display("FAIL wrap_zf: got %0b want 0", zero_flag);
    end
    wrt_en = 1'b0; done = 1'b1; cyc();
    n_cmp++;
    if (result !== 16'hFFFF) begin
      n_err++; $display("FAIL wrap_value: got %h want ffff", result);
    end
    done = 1'b0;
    drive(OP_CLR, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 16'hB520); cyc();
    drive(OP_CLR, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 16'h7A10); cyc();
    drive(OP_ADD, 2'd0, 2'd2, 2'd1, 1'b1, 1'b0, '0);      cyc();
    drive(OP_INC, 2'd3, 2'd0, 2'd3, 1'b1, 1'b0, '0);      cyc();
    n_cmp++;
`ifdef FIBO_OVF_EN
    if (overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky: got %0b want 1", overflow);
    end
`else
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_disabled: got %0b want 0", overflow);
    end
`endif
    wrt_en = 1'b0; done = 1'b1; cyc();
    n_cmp++;
    if (result !== 16'h2F30) begin
      n_err++; $display("FAIL ovf_sum: got %h want 2f30", result);
    end
    done = 1'b0;
    drive(OP_CLR, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 16'd3); cyc();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear_on_load: got %0b want 0", overflow);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
      done = ($urandom_range(0, 2) == 0);
      cyc();
      n_cmp++;
      if (zero_flag !== m_zero || result !== m_result || result_valid !== m_valid || overflow !== m_ovf) begin
        n_err++;
        $display("FAIL random_c%0d: got zf=%0b res=%h rv=%0b ovf=%0b want zf=%0b res=%h rv=%0b ovf=%0b",
                 c, zero_flag, result, result_valid, overflow, m_zero, m_result, m_valid, m_ovf);
      end
    end
    done = 1'b0; wrt_en = 1'b0; cyc();
  endtask

  task automatic test_async_reset();
    drive(OP_CLR, 2'd0, 2'd0, RADDR, 1'b1, 1'b1, 16'h1234); cyc();
    wrt_en = 1'b0; done = 1'b1; cyc();
    done = 1'b0;
    drive(OP_CLR, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 16'd0); cyc();
    n_cmp++;
    if (result !== 16'h1234 || zero_flag !== 1'b1) begin
      n_err++; $display("FAIL arst_setup: got res=%h zf=%0b want 1234/1", result, zero_flag);
    end
    wrt_en = 1'b0;
    done = 1'b1;   // rising edge pending at the next clock
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({zero_flag, result, result_valid, overflow} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL arst_immediate: got zf=%0b res=%h rv=%0b ovf=%0b want all 0", zero_flag, result, result_valid, overflow);
    end
    @(posedge clk); #1;
    done = 1'b0;
    rst_n = 1'b1;
    model_reset();
    cyc();
    n_cmp++;
    if (result_valid !== 1'b0 || result !== 16'd0) begin
      n_err++; $display("FAIL arst_edge_discarded: got rv=%0b res=%h want 0/0", result_valid, result);
    end
    drive(OP_PASA, RADDR, 2'd0, RADDR, 1'b1, 1'b0, '0); cyc();
    n_cmp++;
    if (zero_flag !== 1'b1) begin
      n_err++; $display("FAIL arst_rf_cleared: got zf=%0b want 1", zero_flag);
    end
    wrt_en = 1'b0; cyc();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    test_reset();
    test_load();
    test_fib_sequence();
    test_read_during_write();
    test_wrap_and_overflow();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
